// File: rtl/pipeline_control_unit.sv
// Hazard-aware control unit: decodes IF/ID and carries control through ID/EX, EX/MEM and MEM/WB.
// Define PIPE_FORWARDING_EN to enable EX/MEM and MEM/WB operand forwarding (otherwise RAW hazards stall).
module pipeline_control_unit #(
  parameter int REG_ADDR_W = 3,
  parameter int INSTR_W    = 19
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [INSTR_W-1:0]    instr_id,
  input  logic                  instr_valid,
  input  logic                  ext_stall,
  input  logic                  c_flag,
  input  logic                  z_flag,
  output logic                  stall_if,
  output logic                  flush_id,
  output logic [1:0]            pc_mux,
  output logic                  id_reg_b_mux,
  output logic [2:0]            ex_alu_op,
  output logic                  ex_alu_use_carry,
  output logic                  ex_alu_b_mux,
  output logic                  ex_select_c,
  output logic                  ex_select_z,
  output logic                  ex_write_c,
  output logic                  ex_write_z,
  output logic                  push,
  output logic                  pop,
  output logic                  mem_write,
  output logic                  mem_read,
  output logic                  wb_reg_write,
  output logic [1:0]            wb_reg_write_mux,
  output logic [REG_ADDR_W-1:0] wb_rd,
  output logic [1:0]            fwd_a,
  output logic [1:0]            fwd_b
);

  localparam int R = REG_ADDR_W;

  typedef struct packed {
    logic [2:0]   alu_op;
    logic         use_carry;
    logic         alu_b_mux;
    logic         sel_cz;
    logic         write_cz;
    logic         mem_write;
    logic         mem_read;
    logic         reg_write;
    logic [1:0]   wb_mux;
    logic [R-1:0] rd;
    logic         use_a;
    logic [R-1:0] src_a;
    logic         use_b;
    logic [R-1:0] src_b;
    logic         is_br;
    logic         br_c;
    logic         br_inv;
    logic         is_jmp;
    logic         is_jsb;
    logic         is_ret;
  } ctrl_t;

  typedef struct packed {
    logic         mem_write;
    logic         mem_read;
    logic         reg_write;
    logic [1:0]   wb_mux;
    logic [R-1:0] rd;
  } late_t;

  ctrl_t        dec, id_ex;
  late_t        ex_mem;
  logic [R-1:0] rd_f, rs_f, rt_f;
  logic [2:0]   op3;
  logic         taken, hazard, hit_ex, br_flag;
  logic         unused_bits;

  assign op3  = instr_id[INSTR_W-1 -: 3];
  assign rd_f = instr_id[13 -: R];
  assign rs_f = instr_id[13-R -: R];
  assign rt_f = instr_id[13-2*R -: R];
  assign unused_bits = ^instr_id[13-3*R:0];

  // rd is only carried for register writers so later stages never see a stale destination
  always_comb begin
    dec = '0;
    if (instr_valid) begin
      casez (op3)
        3'b0??: begin
          dec.alu_op    = instr_id[16:14];
          dec.use_carry = instr_id[14];
          dec.alu_b_mux = instr_id[17];
          dec.write_cz  = 1'b1;
          dec.reg_write = 1'b1;
          dec.rd        = rd_f;
          dec.use_a     = 1'b1;
          dec.src_a     = rs_f;
          dec.use_b     = ~instr_id[17];
          dec.src_b     = rt_f;
        end
        3'b100: begin
          dec.alu_b_mux = 1'b1;
          dec.use_a     = 1'b1;
          dec.src_a     = rs_f;
          if (instr_id[14]) begin
            dec.mem_write = 1'b1;
            dec.use_b     = 1'b1;
            dec.src_b     = rd_f;
          end else begin
            dec.mem_read  = 1'b1;
            dec.reg_write = 1'b1;
            dec.wb_mux    = 2'b10;
            dec.rd        = rd_f;
          end
        end
        3'b101: begin
          dec.is_br  = 1'b1;
          dec.br_c   = instr_id[15];
          dec.br_inv = instr_id[14];
        end
        3'b110: begin
          dec.sel_cz    = 1'b1;
          dec.write_cz  = 1'b1;
          dec.reg_write = 1'b1;
          dec.wb_mux    = 2'b01;
          dec.rd        = rd_f;
          dec.use_a     = 1'b1;
          dec.src_a     = rs_f;
        end
        3'b111: begin
          if (!instr_id[15]) begin
            dec.is_jmp = 1'b1;
            dec.is_jsb = instr_id[14];
          end else if (!instr_id[14]) begin
            dec.is_ret = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign br_flag = id_ex.br_c ? c_flag : z_flag;
  assign taken   = (id_ex.is_br & (br_flag ^ id_ex.br_inv)) | id_ex.is_jmp | id_ex.is_ret;

  always_comb begin
    pc_mux = 2'b00;
    if (id_ex.is_ret)                    pc_mux = 2'b11;
    else if (id_ex.is_jmp)               pc_mux = 2'b10;
    else if (id_ex.is_br && taken)       pc_mux = 2'b01;
  end

  assign hit_ex = id_ex.reg_write &&
                  ((dec.use_a && dec.src_a == id_ex.rd) || (dec.use_b && dec.src_b == id_ex.rd));

`ifdef PIPE_FORWARDING_EN
  assign hazard = hit_ex && id_ex.mem_read;

  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (id_ex.use_a && ex_mem.reg_write && ex_mem.rd == id_ex.src_a)   fwd_a = 2'b01;
    else if (id_ex.use_a && wb_reg_write && wb_rd == id_ex.src_a)      fwd_a = 2'b10;
    if (id_ex.use_b && ex_mem.reg_write && ex_mem.rd == id_ex.src_b)   fwd_b = 2'b01;
    else if (id_ex.use_b && wb_reg_write && wb_rd == id_ex.src_b)      fwd_b = 2'b10;
  end
`else
  logic hit_mem;
  logic unused_src;

  assign hit_mem = ex_mem.reg_write &&
                   ((dec.use_a && dec.src_a == ex_mem.rd) || (dec.use_b && dec.src_b == ex_mem.rd));
  assign hazard  = hit_ex || hit_mem;
  assign fwd_a   = 2'b00;
  assign fwd_b   = 2'b00;
  assign unused_src = ^{id_ex.use_a, id_ex.src_a, id_ex.use_b, id_ex.src_b};
`endif

  assign stall_if = ext_stall | (hazard & ~taken);
  assign flush_id = taken & ~ext_stall;

  always_ff @(posedge clk) begin
    if (reset) begin
      id_ex            <= '0;
      ex_mem           <= '0;
      wb_reg_write     <= 1'b0;
      wb_reg_write_mux <= 2'b00;
      wb_rd            <= '0;
    end else if (!ext_stall) begin
      wb_reg_write     <= ex_mem.reg_write;
      wb_reg_write_mux <= ex_mem.wb_mux;
      wb_rd            <= ex_mem.rd;
      ex_mem           <= '{mem_write: id_ex.mem_write, mem_read: id_ex.mem_read,
                            reg_write: id_ex.reg_write, wb_mux: id_ex.wb_mux, rd: id_ex.rd};
      id_ex            <= (taken || hazard) ? '0 : dec;
    end
  end

  assign id_reg_b_mux     = instr_valid && (op3 == 3'b100);
  assign ex_alu_op        = id_ex.alu_op;
  assign ex_alu_use_carry = id_ex.use_carry;
  assign ex_alu_b_mux     = id_ex.alu_b_mux;
  assign ex_select_c      = id_ex.sel_cz;
  assign ex_select_z      = id_ex.sel_cz;
  assign ex_write_c       = id_ex.write_cz & ~ext_stall;
  assign ex_write_z       = id_ex.write_cz & ~ext_stall;
  assign push             = id_ex.is_jsb & ~ext_stall;
  assign pop              = id_ex.is_ret & ~ext_stall;
  assign mem_write        = ex_mem.mem_write & ~ext_stall;
  assign mem_read         = ex_mem.mem_read;

endmodule
